// File: rtl/global_defs.sv
// Project-wide types and constants shared by the trace parser and the memory request queue.
package global_defs;

  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned QUEUE_DEPTH   = 16;
  localparam int unsigned STAMP_WIDTH   = 32;

  // 3-bit encoding leaves room for future opcodes; only NOP/READ/WRITE/IFETCH are legal today.
  typedef enum logic [2:0] {
    OpNop    = 3'd0,
    OpRead   = 3'd1,
    OpWrite  = 3'd2,
    OpIfetch = 3'd3
  } parsed_op_t;

  typedef struct packed {
    parsed_op_t                 op;
    logic [ADDRESS_WIDTH-1:0]   addr;
    logic [STAMP_WIDTH-1:0]     stamp;
  } queue_entry_t;

  function automatic logic is_legal_op(parsed_op_t op);
    return (op == OpRead) || (op == OpWrite) || (op == OpIfetch);
  endfunction

endpackage

// File: rtl/mem_request_queue_if.sv
// Parser-facing push side and scheduler-facing head/pop side of the memory request queue.
interface mem_request_queue_if #(
  parameter int unsigned DEPTH       = global_defs::QUEUE_DEPTH,
  parameter int unsigned STAMP_WIDTH = global_defs::STAMP_WIDTH
);
  import global_defs::*;

  logic                     op_ready_s;
  parsed_op_t               opcode;
  logic [ADDRESS_WIDTH-1:0] address;

  logic                     head_valid;
  parsed_op_t               head_opcode;
  logic [ADDRESS_WIDTH-1:0] head_address;
  logic [STAMP_WIDTH-1:0]   head_age;
  logic                     pop;

  logic [$clog2(DEPTH):0]   occupancy;
  logic                     full;
  logic                     empty;
  logic                     overflow_err;

  modport slave (
    input  op_ready_s, opcode, address, pop,
    output head_valid, head_opcode, head_address, head_age,
    output occupancy, full, empty, overflow_err
  );

  modport master (
    output op_ready_s, opcode, address, pop,
    input  head_valid, head_opcode, head_address, head_age,
    input  occupancy, full, empty, overflow_err
  );

endinterface

// File: rtl/queue_storage.sv
// Entry register array: one synchronous write port, one asynchronous read port.
module queue_storage
  import global_defs::*;
#(
  parameter int unsigned DEPTH = QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  queue_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output queue_entry_t             rdata
);

  queue_entry_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_request_queue.sv
// In-order request queue between the trace parser and the DRAM command scheduler.
// Entries carry their arrival cycle so the scheduler can see how long the head has waited.
module mem_request_queue #(
  parameter int unsigned DEPTH       = global_defs::QUEUE_DEPTH,
  parameter int unsigned STAMP_WIDTH = global_defs::STAMP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_request_queue_if.slave    bus
);
  import global_defs::*;

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [STAMP_WIDTH-1:0] cycle_q;
  logic                   overflow_q, overflow_d;

  logic                   push_req;
  logic                   do_push;
  logic                   do_pop;
  logic                   drop;
  logic                   is_full;
  logic                   is_empty;
  queue_entry_t           wr_entry;
  queue_entry_t           rd_entry;

  // Pop is resolved first so a full queue can still take a push in the same cycle.
  always_comb begin
    push_req   = bus.op_ready_s && (bus.opcode != OpNop);
    is_full    = (count_q == CntW'(DEPTH));
    is_empty   = (count_q == '0);
    do_pop     = bus.pop && !is_empty;
    do_push    = push_req && (!is_full || do_pop);
    drop       = push_req && !do_push;

    wr_ptr_d   = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    overflow_d = overflow_q || drop;

    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    wr_entry       = '0;
    wr_entry.op    = bus.opcode;
    wr_entry.addr  = bus.address;
    wr_entry.stamp = cycle_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_q + STAMP_WIDTH'(1);
      overflow_q <= overflow_d;
    end
  end

  queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Stale storage is masked so an empty queue always presents a clean NOP head.
  always_comb begin
    bus.head_valid   = !is_empty;
    bus.head_opcode  = is_empty ? OpNop : rd_entry.op;
    bus.head_address = is_empty ? '0 : rd_entry.addr;
    bus.head_age     = is_empty ? '0 : (cycle_q - rd_entry.stamp);
    bus.occupancy    = count_q;
    bus.full         = is_full;
    bus.empty        = is_empty;
    bus.overflow_err = overflow_q;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (push_req) begin
        assert (is_legal_op(bus.opcode))
          else $error("mem_request_queue: push of illegal opcode %0d", bus.opcode);
      end
      if (drop && !overflow_q) begin
        $warning("mem_request_queue: queue full, request dropped (overflow_err set)");
      end
    end
  end

endmodule

// File: doc/mem_request_queue.md
Name: mem_request_queue

Overview:
- Sits directly downstream of the trace parser. Captures each parsed memory request (opcode and address) on the parser's one-cycle strobe.
- Holds requests in order in a bounded queue and timestamps each entry with its arrival cycle.
- Presents the oldest entry, with its age, to the DRAM command scheduler through a valid/pop handshake.
- Reports occupancy, full/empty, and a sticky overflow error, because the parser has no backpressure.

Parameters:
- DEPTH, 16, number of queue entries; power of two, minimum 2.
- STAMP_WIDTH, 32, width of the internal cycle counter, arrival stamps and head_age.
- Address width is ADDRESS_WIDTH from global_defs; it is not a local parameter.

Ports:
- clk  in  1  system clock, the same clock the parser runs on.
- rst_n  in  1  asynchronous active-low reset.
- op_ready_s  in  1  parser strobe; a new request is valid this cycle.
- opcode  in  parsed_op_t  parser opcode.
- address  in  ADDRESS_WIDTH  parser address.
- head_valid  out  1  the queue is non-empty; head_* fields are valid.
- head_opcode  out  parsed_op_t  opcode of the oldest entry.
- head_address  out  ADDRESS_WIDTH  address of the oldest entry.
- head_age  out  STAMP_WIDTH  cycle_count minus the head entry's arrival stamp.
- pop  in  1  scheduler consumes the head this cycle; ignored when head_valid=0.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries, range 0..DEPTH.
- full  out  1  occupancy==DEPTH.
- empty  out  1  occupancy==0.
- overflow_err  out  1  sticky; a request was dropped since reset.

Behaviour:
- Reset: clk with asynchronous active-low rst_n. While rst_n=0, all state clears immediately.
  - occupancy=0, empty=1, full=0, head_valid=0, overflow_err=0.
  - head_opcode=NOP, head_address=0, head_age=0.
  - Read/write pointers and cycle_count are 0.
  - Reset mid-operation discards all entries; nothing is flushed or replayed.
- cycle_count: free-running, increments every clk after reset, wraps modulo 2^STAMP_WIDTH.
  - head_age is computed as modulo subtraction, so it stays correct across wrap.
- Push condition: op_ready_s=1 and opcode!=NOP.
  - The entry {opcode, address, stamp=cycle_count} is written at the write pointer on the clock edge.
  - A strobe carrying NOP is ignored and is not counted.
- Pop: pop=1 with head_valid=1 retires the head on the clock edge.
- Latency: a push at edge N makes head_valid=1 after edge N when the queue was empty.
  - There is no combinational bypass from the inputs to head_*.
- Head outputs: head_* are driven from storage at the read pointer.
  - When empty, head_opcode=NOP, head_address=0 and head_age=0.
- Pointers: $clog2(DEPTH) bits each, wrapping naturally DEPTH-1 -> 0.
  - occupancy is a separate counter: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full plus push plus pop in the same cycle: the push is accepted and occupancy stays DEPTH. Pop is evaluated first.
- Full plus push with no pop: the request is dropped and storage is unchanged. overflow_err sets and stays 1 until reset.
- Empty plus push plus pop: pop is ignored (head_valid=0) and the push is accepted, giving occupancy=1.
- pop while empty: no effect, no error.
- full, empty and occupancy are registered-state derived: they update on the edge, never combinationally from inputs.
- Assertions, simulation only:
  - $error on push of an opcode outside the READ, WRITE and IFETCH encodings.
  - $warning when overflow_err first sets.

Decomposition:
- global_defs:
  - add queue_entry_t, a packed struct {parsed_op_t op; logic [ADDRESS_WIDTH-1:0] addr; logic [STAMP_WIDTH-1:0] stamp}.
  - add QUEUE_DEPTH=16 and STAMP_WIDTH=32 constants.
  - reuse the existing parsed_op_t and ADDRESS_WIDTH.
- One sub-module, queue_storage: DEPTH x queue_entry_t register array with a single write port and a single asynchronous read port.
  - Pointer, occupancy and error control stay in mem_request_queue.

Test Plan:
- Reset with rst_n=0 applied mid-cycle (asynchronous) -> empty=1, occupancy=0, head_valid=0 and overflow_err=0 immediately, without waiting for a clock edge.
- Single push READ 0x1A2B3C at cycle_count=5, no pop for 3 cycles:
  - head_valid=1 one edge later, head_address=0x1A2B3C.
  - head_age reads 1, 2, 3 on consecutive cycles.
- Push 16 distinct requests, then a 17th:
  - full=1 after the 16th, overflow_err=1 after the 17th, occupancy=16.
  - Popping 16 times returns addresses in push order and excludes the 17th.
- Full queue with push and pop in the same cycle:
  - occupancy stays 16 and overflow_err stays 0.
  - The new entry emerges as the 16th subsequent pop.
- Empty queue with push WRITE 0x40 plus pop same cycle -> occupancy=1, head_opcode=WRITE.
  - 40 push/pop cycles exercise pointer wrap with data matching throughout.
- cycle_count wrap: force the stamp to 2^32-2 on push and hold 4 cycles -> head_age=4.
  - An op_ready_s strobe with NOP -> occupancy unchanged.
